// File: rtl/clint_pkg.sv
// Shared register offsets, reset constants and address decode for the CLINT timer block.
// Optional mtime counter is controlled by the CLINT_MTIME_EN macro.
package clint_pkg;

  localparam int unsigned CLINT_ADDR_W = 5;
  localparam int unsigned CLINT_DATA_W = 32;

  localparam logic [CLINT_ADDR_W-1:0] CLINT_MSIP     = 5'h00;
  localparam logic [CLINT_ADDR_W-1:0] CLINT_CMP_LO   = 5'h08;
  localparam logic [CLINT_ADDR_W-1:0] CLINT_CMP_HI   = 5'h0C;
  localparam logic [CLINT_ADDR_W-1:0] CLINT_MTIME_LO = 5'h10;
  localparam logic [CLINT_ADDR_W-1:0] CLINT_MTIME_HI = 5'h14;

  // All-ones compare value keeps mtime >= mtimecmp false until software programs it.
  localparam logic [63:0] CLINT_MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [31:0] CLINT_SHADOW_RST   = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    REG_MSIP,
    REG_CMP_LO,
    REG_CMP_HI,
    REG_MTIME_LO,
    REG_MTIME_HI,
    REG_NONE
  } clint_reg_e;

  function automatic clint_reg_e clint_decode(input logic [CLINT_ADDR_W-1:0] addr);
    logic [CLINT_ADDR_W-1:0] word_addr;
    clint_reg_e sel;
    word_addr = {addr[CLINT_ADDR_W-1:2], 2'b00};
    case (word_addr)
      CLINT_MSIP:     sel = REG_MSIP;
      CLINT_CMP_LO:   sel = REG_CMP_LO;
      CLINT_CMP_HI:   sel = REG_CMP_HI;
      CLINT_MTIME_LO: sel = REG_MTIME_LO;
      CLINT_MTIME_HI: sel = REG_MTIME_HI;
      default:        sel = REG_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/clint_mtime.sv
// Free-running 64-bit mtime counter with a high-word snapshot taken on each low-word read,
// so a lo-then-hi read pair is coherent across a carry. Only built under CLINT_MTIME_EN.
module clint_mtime
  import clint_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        snap_en,
  output logic [31:0] count_lo,
  output logic [31:0] snapshot
);

  logic [63:0] count_reg;
  logic [31:0] snap_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
      snap_reg  <= '0;
    end else begin
      count_reg <= count_reg + 64'd1;
      if (snap_en) begin
        snap_reg <= count_reg[63:32];
      end
    end
  end

  assign count_lo = count_reg[31:0];
  assign snapshot = snap_reg;

endmodule

// File: rtl/clint_timer.sv
// CLINT timer register block: MSIP, shadowed atomic mtimecmp, optional mtime (CLINT_MTIME_EN).
// Single-cycle req/ack bus; ack, err and rdata are registered and valid for exactly one cycle.
module clint_timer
  import clint_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        err,
  output logic [63:0] mtimecmp,
  output logic        msip
);

  clint_reg_e  sel;
  logic        accept;
  logic        ack_reg;
  logic        err_reg;
  logic        msip_reg;
  logic [31:0] rdata_reg;
  logic [31:0] rdata_next;
  logic [31:0] shadow_reg;
  logic [63:0] mtimecmp_reg;
  logic [31:0] mtime_lo;
  logic [31:0] mtime_hi;

  assign sel = clint_decode(addr);

  // Blocking acceptance during the ack cycle stops a held request being counted twice.
  assign accept = req && !ack_reg;

`ifdef CLINT_MTIME_EN
  clint_mtime u_mtime (
    .clk      (clk),
    .reset    (reset),
    .snap_en  (accept && !we && (sel == REG_MTIME_LO)),
    .count_lo (mtime_lo),
    .snapshot (mtime_hi)
  );
`else
  assign mtime_lo = '0;
  assign mtime_hi = '0;
`endif

  always_comb begin
    rdata_next = '0;
    case (sel)
      REG_MSIP:     rdata_next = {31'b0, msip_reg};
      REG_CMP_LO:   rdata_next = shadow_reg;
      REG_CMP_HI:   rdata_next = mtimecmp_reg[63:32];
      REG_MTIME_LO: rdata_next = mtime_lo;
      REG_MTIME_HI: rdata_next = mtime_hi;
      default:      rdata_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ack_reg      <= 1'b0;
      err_reg      <= 1'b0;
      rdata_reg    <= '0;
      msip_reg     <= 1'b0;
      shadow_reg   <= CLINT_SHADOW_RST;
      mtimecmp_reg <= CLINT_MTIMECMP_RST;
    end else begin
      ack_reg   <= accept;
      err_reg   <= accept && (sel == REG_NONE);
      rdata_reg <= (accept && !we) ? rdata_next : '0;
      if (accept && we) begin
        case (sel)
          REG_MSIP:   msip_reg     <= wdata[0];
          REG_CMP_LO: shadow_reg   <= wdata;
          REG_CMP_HI: mtimecmp_reg <= {wdata, shadow_reg};
          default:    ;
        endcase
      end
    end
  end

  assign ack      = ack_reg;
  assign err      = err_reg;
  assign rdata    = rdata_reg;
  assign mtimecmp = mtimecmp_reg;
  assign msip     = msip_reg;

endmodule

// File: tb/tb_clint_timer.sv
// Self-checking bench for clint_timer: directed vector table, multi-cycle corner sequences,
// and randomized transactions checked against a register-map model.
module tb_clint_timer;

`ifdef CLINT_MTIME_EN
  localparam bit MTIME_EN = 1'b1;
`else
  localparam bit MTIME_EN = 1'b0;
`endif

  localparam logic [63:0] ONES64 = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic        err;
  logic [63:0] mtimecmp;
  logic        msip;

  always #5 clk = ~clk;

  clint_timer dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .ack      (ack),
    .err      (err),
    .mtimecmp (mtimecmp),
    .msip     (msip)
  );

  int tests = 0;
  int fails = 0;

  // Reference model of the architecturally visible registers.
  logic [63:0] m_cmp;
  logic [31:0] m_shadow;
  logic        m_msip;

  typedef struct {
    logic        w;
    logic [4:0]  a;
    logic [31:0] d;
    logic        chk;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_apply(input logic w, input logic [4:0] a, input logic [31:0] d,
                             output logic [31:0] erd, output logic eerr, output logic is_mtime);
    erd = '0;
    eerr = 1'b0;
    is_mtime = 1'b0;
    case (a[4:2])
      3'd0: if (w) m_msip = d[0]; else erd = {31'b0, m_msip};
      3'd2: if (w) m_shadow = d; else erd = m_shadow;
      3'd3: if (w) m_cmp = {d, m_shadow}; else erd = m_cmp[63:32];
      3'd4, 3'd5: is_mtime = 1'b1;
      default: eerr = 1'b1;
    endcase
  endtask

  // Issues one request at the current time (just after an edge); returns the ack-cycle outputs.
  task automatic do_txn(input logic w, input logic [4:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic er, output logic ak);
    req = 1'b1;
    we = w;
    addr = a;
    wdata = d;
    @(posedge clk);
    #1;
    ak = ack;
    rd = rdata;
    er = err;
    req = 1'b0;
    we = 1'b0;
    $display("[TB] txn %s addr=0x%02h wdata=0x%08h -> ack=%0b err=%0b rdata=0x%08h",
             w ? "WR" : "RD", a, d, ak, er, rd);
    @(posedge clk);
    #1;
    check("idle_ack", {63'b0, ack}, 64'd0);
    check("idle_rdata", {32'b0, rdata}, 64'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] erd;
    logic        er;
    logic        ak;
    logic        eerr;
    logic        is_mt;
    logic        w;
    logic [4:0]  a;
    logic [31:0] d;

    reset = 1'b1;
    req = 1'b0;
    we = 1'b0;
    addr = '0;
    wdata = '0;
    m_cmp = ONES64;
    m_shadow = 32'hFFFF_FFFF;
    m_msip = 1'b0;

    vecs[0]  = '{1'b0, 5'h0C, 32'h0,         1'b1, 32'hFFFF_FFFF, 1'b0};
    vecs[1]  = '{1'b0, 5'h00, 32'h0,         1'b1, 32'h0,         1'b0};
    vecs[2]  = '{1'b0, 5'h08, 32'h0,         1'b1, 32'hFFFF_FFFF, 1'b0};
    vecs[3]  = '{1'b0, 5'h18, 32'h0,         1'b1, 32'h0,         1'b1};
    vecs[4]  = '{1'b1, 5'h1C, 32'h1234_5678, 1'b0, 32'h0,         1'b1};
    vecs[5]  = '{1'b0, 5'h04, 32'h0,         1'b1, 32'h0,         1'b1};
    vecs[6]  = '{1'b1, 5'h00, 32'hFFFF_FFFF, 1'b0, 32'h0,         1'b0};
    vecs[7]  = '{1'b0, 5'h00, 32'h0,         1'b1, 32'h1,         1'b0};
    vecs[8]  = '{1'b0, 5'h03, 32'h0,         1'b1, 32'h1,         1'b0};
    vecs[9]  = '{1'b1, 5'h00, 32'hFFFF_FFFE, 1'b0, 32'h0,         1'b0};
    vecs[10] = '{1'b0, 5'h01, 32'h0,         1'b1, 32'h0,         1'b0};
    vecs[11] = '{1'b1, 5'h10, 32'hDEAD_BEEF, 1'b0, 32'h0,         1'b0};
    vecs[12] = '{1'b1, 5'h14, 32'h1,         1'b0, 32'h0,         1'b0};
    vecs[13] = '{1'b0, 5'h10, 32'h0,         !MTIME_EN, 32'h0,    1'b0};
    vecs[14] = '{1'b0, 5'h14, 32'h0,         !MTIME_EN, 32'h0,    1'b0};
    vecs[15] = '{1'b0, 5'h08, 32'h0,         1'b1, 32'hFFFF_FFFF, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", {63'b0, ack}, 64'd0);
    check("rst_err", {63'b0, err}, 64'd0);
    check("rst_rdata", {32'b0, rdata}, 64'd0);
    check("rst_mtimecmp", mtimecmp, ONES64);
    check("rst_msip", {63'b0, msip}, 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Directed vector table.
    for (int i = 0; i < 16; i++) begin
      model_apply(vecs[i].w, vecs[i].a, vecs[i].d, erd, eerr, is_mt);
      do_txn(vecs[i].w, vecs[i].a, vecs[i].d, rd, er, ak);
      check("tbl_ack", {63'b0, ak}, 64'd1);
      check("tbl_err", {63'b0, er}, {63'b0, vecs[i].exp_err});
      if (vecs[i].chk) check("tbl_rdata", {32'b0, rd}, {32'b0, vecs[i].exp_rd});
      check("tbl_mtimecmp", mtimecmp, m_cmp);
      check("tbl_msip", {63'b0, msip}, {63'b0, m_msip});
    end

    // Atomic commit: the low half waits in the shadow until the high half is written.
    model_apply(1'b1, 5'h08, 32'h10, erd, eerr, is_mt);
    do_txn(1'b1, 5'h08, 32'h10, rd, er, ak);
    check("commit_lo_hold", mtimecmp, ONES64);
    req = 1'b1;
    we = 1'b1;
    addr = 5'h0C;
    wdata = 32'h0;
    #3;
    check("commit_pre", mtimecmp, ONES64);
    @(posedge clk);
    #1;
    check("commit_ack", {63'b0, ack}, 64'd1);
    check("commit_val", mtimecmp, 64'h0000_0000_0000_0010);
    req = 1'b0;
    we = 1'b0;
    m_cmp = 64'h10;
    @(posedge clk);
    #1;

    // Held request: four cycles of req yields two single-cycle acks two cycles apart.
    req = 1'b1;
    we = 1'b1;
    addr = 5'h00;
    wdata = 32'h1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      check("held_ack", {63'b0, ack}, {63'b0, (c % 2 == 0)});
    end
    req = 1'b0;
    we = 1'b0;
    m_msip = 1'b1;
    check("held_msip", {63'b0, msip}, 64'd1);
    @(posedge clk);
    #1;

    // Reset in the accept cycle of a CMP_HI write.
    req = 1'b1;
    we = 1'b1;
    addr = 5'h0C;
    wdata = 32'h5;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rstmid_ack", {63'b0, ack}, 64'd0);
    check("rstmid_mtimecmp", mtimecmp, ONES64);
    check("rstmid_msip", {63'b0, msip}, 64'd0);
    reset = 1'b0;
    req = 1'b0;
    we = 1'b0;
    m_cmp = ONES64;
    m_shadow = 32'hFFFF_FFFF;
    m_msip = 1'b0;
    @(posedge clk);
    #1;
    check("rstmid_noack", {63'b0, ack}, 64'd0);
    check("rstmid_keep", mtimecmp, ONES64);

`ifdef CLINT_MTIME_EN
    // Low word read just before a carry; the high read must return the pre-carry snapshot.
    dut.u_mtime.count_reg = 64'h0000_0000_FFFF_FFFE;
    do_txn(1'b0, 5'h10, 32'h0, rd, er, ak);
    check("carry_lo", {32'b0, rd}, 64'hFFFF_FFFE);
    do_txn(1'b0, 5'h14, 32'h0, rd, er, ak);
    check("carry_hi", {32'b0, rd}, 64'h0);
    check("carry_err", {63'b0, er}, 64'd0);
`endif

    // Randomized transactions against the model.
    for (int i = 0; i < 150; i++) begin
      w = 1'($urandom_range(0, 1));
      a = 5'($urandom_range(0, 31));
      d = $urandom;
      model_apply(w, a, d, erd, eerr, is_mt);
      do_txn(w, a, d, rd, er, ak);
      check("rnd_ack", {63'b0, ak}, 64'd1);
      check("rnd_err", {63'b0, er}, {63'b0, eerr});
      if (!w && !(is_mt && MTIME_EN)) check("rnd_rdata", {32'b0, rd}, {32'b0, erd});
      check("rnd_mtimecmp", mtimecmp, m_cmp);
      check("rnd_msip", {63'b0, msip}, {63'b0, m_msip});
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/clint_timer.md
CLINT_TIMER -- requirements
Module: clint_timer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-003 SHALL have port req, input, 1 bit: bus request, held by the master until ack.
REQ-004 SHALL have port we, input, 1 bit: 1 = write, 0 = read; qualified by req.
REQ-005 SHALL have port addr, input, 5 bits: byte offset; bits [1:0] ignored.
REQ-006 SHALL have port wdata, input, 32 bits: write data.
REQ-007 SHALL have port rdata, output, 32 bits: read data, valid only while ack=1, else 0.
REQ-008 SHALL have port ack, output, 1 bit: one-cycle completion pulse.
REQ-009 SHALL have port err, output, 1 bit: asserted with ack for an unmapped offset.
REQ-010 SHALL have port mtimecmp, output, 64 bits: committed compare value for the CSR file's timer comparison.
REQ-011 SHALL have port msip, output, 1 bit: software-interrupt request level.

Function
REQ-012 SHALL use this register map: 0x00 MSIP (bit0 R/W, other bits read 0); 0x08 CMP_LO (shadow, R/W); 0x0C CMP_HI (R/W, commit); 0x10 MTIME_LO (RO); 0x14 MTIME_HI (RO snapshot).
REQ-013 SHALL accept a transaction in any cycle where req=1 and ack=0, and SHALL assert ack in the next cycle.
REQ-014 SHALL latch rdata from the register value sampled in the accept cycle.
REQ-015 SHALL NOT accept while ack=1, so a request held through the ack cycle is never double-counted.
REQ-016 SHALL, on a write to CMP_LO, update only the 32-bit shadow; mtimecmp stays unchanged.
REQ-017 SHALL, on a write to CMP_HI, update mtimecmp atomically to {wdata, shadow} in one cycle.
REQ-018 SHALL return the shadow on a CMP_LO read and mtimecmp[63:32] on a CMP_HI read.
REQ-019 SHALL, on a write to MSIP, set msip to wdata[0], taking effect in the cycle after accept.
REQ-020 SHALL, on an unmapped offset, assert err with ack, return rdata=0, and ignore the write.
REQ-021 SHALL treat writes to MTIME_LO/MTIME_HI as no-ops, with no err.
REQ-022 SHALL, when CLINT_MTIME_EN is defined: increment a free-running 64-bit counter every cycle, wrapping from 0xFFFF_FFFF_FFFF_FFFF to 0.
REQ-023 SHALL, when CLINT_MTIME_EN is defined: on a MTIME_LO read, return counter[31:0] and capture counter[63:32] into the snapshot in the same cycle.
REQ-024 SHALL, when CLINT_MTIME_EN is defined: on a MTIME_HI read, return the snapshot, so a lo-then-hi read pair is coherent across a carry.

Reset
REQ-025 SHALL, while reset=1, set mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, shadow=32'hFFFF_FFFF, msip=0, ack=0, err=0, rdata=0, counter=0, snapshot=0.
REQ-026 SHALL, if reset arrives in the accept cycle, produce no ack and commit nothing; the master re-issues the request.
REQ-027 SHALL reset mtimecmp to all-ones so the downstream mtime>=mtimecmp comparison cannot fire before software programs it.

Configuration
REQ-028 SHALL use macro CLINT_MTIME_EN: when defined, the counter and snapshot exist per REQ-022..024.
REQ-029 SHALL, when CLINT_MTIME_EN is undefined, remove the counter and snapshot; MTIME_LO/HI reads return 0 with ack and no err.

Structure
REQ-030 SHALL place the register offsets (CLINT_MSIP, CLINT_CMP_LO, CLINT_CMP_HI, CLINT_MTIME_LO, CLINT_MTIME_HI) and the mtimecmp reset constant in the shared package clint_pkg.
REQ-031 SHALL implement the counter and snapshot in one sub-module, clint_mtime, instantiated only under CLINT_MTIME_EN.

Verification
REQ-032 SHALL cover reset: after reset, read CMP_HI -> rdata=0xFFFFFFFF; read MSIP -> 0; err=0.
REQ-033 SHALL cover atomic commit: write CMP_LO=0x10, check mtimecmp still all-ones; then write CMP_HI=0x0 -> mtimecmp=0x0000_0000_0000_0010 exactly one cycle after accept.
REQ-034 SHALL cover held request: hold req=1 for 4 cycles on one MSIP write of 1 -> two acks, spaced 2 cycles apart, each one cycle wide; msip=1.
REQ-035 SHALL cover an unmapped offset: read 0x18 -> ack=1, err=1, rdata=0; write 0x1C -> no register changes.
REQ-036 SHALL cover mtime carry (with CLINT_MTIME_EN): force counter=0x0000_0000_FFFF_FFFE, read LO then HI -> the pair is a coherent counter value across the carry.
REQ-037 SHALL cover reset mid-transaction: assert reset in the accept cycle of a CMP_HI write of 0x5 -> no ack, and mtimecmp returns to all-ones.
